udma_eth_frame_rx_ctrl: RTL and testbench

- Frame-level RX sequencer between the Ethernet MAC byte stream and the eth_frame RX FIFO.
- Admits one frame at a time into the FIFO and truncates frames on overflow or over-length.
- When a frame completes it issues the set-EOF and set-blocked pulses to the eth_frame config block.
- Holds off further frames until software clears the blocked bit, and counts the frames it drops.

---
 rtl/udma_eth_frame_pkg.sv | 20 ++
 rtl/udma_eth_frame_rx_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_udma_eth_frame_rx_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_eth_frame_pkg.sv
// Shared types and constants for the eth_frame RX path.
package udma_eth_frame_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV      = 3'd1,
        DISCARD   = 3'd2,
        DISCARD_T = 3'd3,
        DONE      = 3'd4,
        WAIT_REL  = 3'd5
    } rx_ctrl_state_e;

    localparam int unsigned STATUS_W    = 3;
    localparam int unsigned ST_OVERFLOW = 0;
    localparam int unsigned ST_OVERLEN  = 1;
    localparam int unsigned ST_MAC_ERR  = 2;

    localparam int unsigned ETH_MAX_FRAME_LEN = 1518;

endpackage

// File: rtl/udma_eth_frame_rx_ctrl.sv
// Frame-level RX sequencer: admits one MAC frame at a time into the RX FIFO,
// reports completion to the config block and waits for software release.
module udma_eth_frame_rx_ctrl
    import udma_eth_frame_pkg::*;
#(
    parameter int unsigned MAX_FRAME_LEN = ETH_MAX_FRAME_LEN,
    parameter int unsigned LEN_W         = 11,
    parameter int unsigned DROP_W        = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                mac_valid_i,
    input  logic [7:0]          mac_data_i,
    input  logic                mac_sof_i,
    input  logic                mac_eof_i,
    input  logic                mac_err_i,
    output logic                fifo_valid_o,
    output logic [7:0]          fifo_data_o,
    input  logic                fifo_ready_i,
    input  logic                cfg_rx_blocked_i,
    output logic                cfg_rx_set_blocked_o,
    output logic                cfg_rx_set_eof_o,
    output logic [LEN_W-1:0]    frame_len_o,
    output logic [STATUS_W-1:0] frame_status_o,
    output logic [DROP_W-1:0]   drop_cnt_o
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

    rx_ctrl_state_e      state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                wr_valid_q, wr_valid_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                seen_hi_q, seen_hi_d;
    logic                rel_pend_q, rel_pend_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [STATUS_W-1:0] fstat_q, fstat_d;
    logic                set_pulse;
    logic                release_now;
    logic [DROP_W-1:0]   drop_inc;

    // Release = blocked bit seen high in an earlier cycle and low now.
    assign release_now = seen_hi_q & ~cfg_rx_blocked_i;
    assign drop_inc    = (&drop_q) ? drop_q : drop_q + DROP_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        wr_valid_d = 1'b0;
        wr_data_d  = wr_data_q;
        drop_d     = drop_q;
        seen_hi_d  = seen_hi_q;
        rel_pend_d = rel_pend_q;
        len_d      = len_q;
        fstat_d    = fstat_q;
        set_pulse  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mac_valid_i && mac_sof_i) begin
                    if (cfg_rx_blocked_i) begin
                        drop_d     = drop_inc;
                        rel_pend_d = 1'b0;
                        if (!mac_eof_i) begin
                            state_d = DISCARD;
                        end
                    end else begin
                        status_d = '0;
                        cnt_d    = '0;
                        if (fifo_ready_i) begin
                            wr_valid_d = 1'b1;
                            wr_data_d  = mac_data_i;
                            cnt_d      = LEN_W'(1);
                        end else begin
                            status_d[ST_OVERFLOW] = 1'b1;
                        end
                        if (mac_eof_i) begin
                            status_d[ST_MAC_ERR] = mac_err_i;
                            state_d              = DONE;
                        end else begin
                            state_d = fifo_ready_i ? RECV : DISCARD_T;
                        end
                    end
                end
            end

            RECV: begin
                if (mac_valid_i) begin
                    if (mac_sof_i) begin
                        // A new SOF cuts the current frame short; the new frame is lost.
                        status_d[ST_MAC_ERR] = 1'b1;
                        state_d              = DONE;
                    end else begin
                        if (!fifo_ready_i) begin
                            status_d[ST_OVERFLOW] = 1'b1;
                        end else if (cnt_q == MAX_LEN) begin
                            status_d[ST_OVERLEN] = 1'b1;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_data_d  = mac_data_i;
                            cnt_d      = cnt_q + LEN_W'(1);
                        end
                        if (mac_eof_i) begin
                            status_d[ST_MAC_ERR] = status_q[ST_MAC_ERR] | mac_err_i;
                            state_d              = DONE;
                        end else if (!fifo_ready_i || cnt_q == MAX_LEN) begin
                            state_d = DISCARD_T;
                        end
                    end
                end
            end

            DISCARD_T: begin
                if (mac_valid_i && mac_eof_i) begin
                    status_d[ST_MAC_ERR] = status_q[ST_MAC_ERR] | mac_err_i;
                    state_d              = DONE;
                end
            end

            DISCARD: begin
                // When entered from WAIT_REL, keep watching for the software release.
                if (rel_pend_q) begin
                    if (cfg_rx_blocked_i) begin
                        seen_hi_d = 1'b1;
                    end
                    if (release_now) begin
                        rel_pend_d = 1'b0;
                        seen_hi_d  = 1'b0;
                        status_d   = '0;
                    end
                end
                if (mac_valid_i && mac_eof_i) begin
                    state_d = (rel_pend_q && !release_now) ? WAIT_REL : IDLE;
                end
            end

            DONE: begin
                // Hold the pulses until the final FIFO write has left the output stage.
                if (!wr_valid_q) begin
                    set_pulse = 1'b1;
                    len_d     = cnt_q;
                    fstat_d   = status_q;
                    seen_hi_d = 1'b0;
                    state_d   = WAIT_REL;
                end
            end

            WAIT_REL: begin
                if (cfg_rx_blocked_i) begin
                    seen_hi_d = 1'b1;
                end
                if (mac_valid_i && mac_sof_i) begin
                    drop_d     = drop_inc;
                    rel_pend_d = ~release_now;
                    if (release_now) begin
                        seen_hi_d = 1'b0;
                        status_d  = '0;
                    end
                    if (!mac_eof_i) begin
                        state_d = DISCARD;
                    end else if (release_now) begin
                        state_d = IDLE;
                    end
                end else if (release_now) begin
                    seen_hi_d = 1'b0;
                    status_d  = '0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            status_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            drop_q     <= '0;
            seen_hi_q  <= 1'b0;
            rel_pend_q <= 1'b0;
            len_q      <= '0;
            fstat_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            drop_q     <= drop_d;
            seen_hi_q  <= seen_hi_d;
            rel_pend_q <= rel_pend_d;
            len_q      <= len_d;
            fstat_q    <= fstat_d;
        end
    end

    assign fifo_valid_o         = wr_valid_q;
    assign fifo_data_o          = wr_data_q;
    assign cfg_rx_set_eof_o     = set_pulse;
    assign cfg_rx_set_blocked_o = set_pulse;
    assign frame_len_o          = len_q;
    assign frame_status_o       = fstat_q;
    assign drop_cnt_o           = drop_q;

endmodule

// File: tb/tb_udma_eth_frame_rx_ctrl.sv
// Directed bench for udma_eth_frame_rx_ctrl: frame table plus multi-cycle corner sequences.
module tb_udma_eth_frame_rx_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mac_valid = 1'b0;
    logic [7:0]  mac_data = 8'h00;
    logic        mac_sof = 1'b0;
    logic        mac_eof = 1'b0;
    logic        mac_err = 1'b0;
    logic        fifo_ready = 1'b1;
    logic        blocked = 1'b0;
    logic        fifo_valid;
    logic [7:0]  fifo_data;
    logic        set_blocked;
    logic        set_eof;
    logic [10:0] frame_len;
    logic [2:0]  frame_status;
    logic [15:0] drop_cnt;

    udma_eth_frame_rx_ctrl #(
        .MAX_FRAME_LEN(1518),
        .LEN_W        (11),
        .DROP_W       (16)
    ) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .mac_valid_i         (mac_valid),
        .mac_data_i          (mac_data),
        .mac_sof_i           (mac_sof),
        .mac_eof_i           (mac_eof),
        .mac_err_i           (mac_err),
        .fifo_valid_o        (fifo_valid),
        .fifo_data_o         (fifo_data),
        .fifo_ready_i        (fifo_ready),
        .cfg_rx_blocked_i    (blocked),
        .cfg_rx_set_blocked_o(set_blocked),
        .cfg_rx_set_eof_o    (set_eof),
        .frame_len_o         (frame_len),
        .frame_status_o      (frame_status),
        .drop_cnt_o          (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Written only by the monitor.
    int wr_total = 0;
    int eof_cnt = 0;
    int blk_cnt = 0;
    int data_err = 0;
    // Written only by the main sequence.
    int seed = 0;
    int frame_base = 0;

    typedef struct {
        int len;
        int rdy_low;
        bit err;
        int exp_wr;
        int exp_len;
        int exp_st;
    } vec_t;

    vec_t vecs[6];

    always @(negedge clk) begin
        if (fifo_valid) begin
            if (fifo_data !== 8'(seed + wr_total - frame_base)) data_err++;
            wr_total++;
        end
        if (set_eof) eof_cnt++;
        if (set_blocked) blk_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    task automatic idle_inputs;
        mac_valid  = 1'b0;
        mac_sof    = 1'b0;
        mac_eof    = 1'b0;
        mac_err    = 1'b0;
        fifo_ready = 1'b1;
    endtask

    // rdy_low: 1-based byte index at which fifo_ready is held low (0 = never).
    task automatic send_frame(input int len, input int rdy_low, input bit err,
                              input bit rel_at_sof, output int early);
        int base_e;
        base_e     = eof_cnt;
        early      = 0;
        frame_base = wr_total;
        for (int i = 0; i < len; i++) begin
            mac_valid  = 1'b1;
            mac_data   = 8'(seed + i);
            mac_sof    = (i == 0);
            mac_eof    = (i == len - 1);
            mac_err    = (i == len - 1) ? err : 1'b0;
            fifo_ready = (i + 1 != rdy_low);
            if (i == 0 && rel_at_sof) blocked = 1'b0;
            if (i == len - 1) early = eof_cnt - base_e;
            tick();
        end
        idle_inputs();
    endtask

    task automatic run_frame(input string nm, input int len, input int rdy_low, input bit err,
                             input int exp_wr, input int exp_len, input int exp_st);
        int base_w, base_e, base_b, base_d, early;
        bit got;
        base_w = wr_total;
        base_e = eof_cnt;
        base_b = blk_cnt;
        base_d = data_err;
        send_frame(len, rdy_low, err, 1'b0, early);
        chk({nm, "_early_pulse"}, early, 0);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (eof_cnt != base_e) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, "_pulse_seen"}, int'(got), 1);
        blocked = 1'b1;
        tick();
        tick();
        chk({nm, "_writes"}, wr_total - base_w, exp_wr);
        chk({nm, "_eof_pulses"}, eof_cnt - base_e, 1);
        chk({nm, "_blk_pulses"}, blk_cnt - base_b, 1);
        chk({nm, "_len"}, int'(frame_len), exp_len);
        chk({nm, "_status"}, int'(frame_status), exp_st);
        chk({nm, "_data"}, data_err - base_d, 0);
    endtask

    task automatic release_sw;
        blocked = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int base_w, base_e, early;

        vecs[0] = '{len: 64,   rdy_low: 0,  err: 1'b0, exp_wr: 64,   exp_len: 64,   exp_st: 0};
        vecs[1] = '{len: 100,  rdy_low: 41, err: 1'b0, exp_wr: 40,   exp_len: 40,   exp_st: 1};
        vecs[2] = '{len: 1600, rdy_low: 0,  err: 1'b1, exp_wr: 1518, exp_len: 1518, exp_st: 6};
        vecs[3] = '{len: 1,    rdy_low: 0,  err: 1'b0, exp_wr: 1,    exp_len: 1,    exp_st: 0};
        vecs[4] = '{len: 10,   rdy_low: 0,  err: 1'b1, exp_wr: 10,   exp_len: 10,   exp_st: 4};
        vecs[5] = '{len: 5,    rdy_low: 5,  err: 1'b0, exp_wr: 4,    exp_len: 4,    exp_st: 1};

        // Reset state.
        repeat (3) tick();
        chk("rst_fifo_valid", int'(fifo_valid), 0);
        chk("rst_set_eof", int'(set_eof), 0);
        chk("rst_frame_len", int'(frame_len), 0);
        chk("rst_status", int'(frame_status), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Table of frames, each released by software afterwards.
        for (int v = 0; v < 6; v++) begin
            seed = 16 * v + 3;
            run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].rdy_low, vecs[v].err,
                      vecs[v].exp_wr, vecs[v].exp_len, vecs[v].exp_st);
            release_sw();
        end

        // Frame arriving before release is dropped whole; block stays waiting.
        seed = 7;
        run_frame("pre_drop", 64, 0, 1'b0, 64, 64, 0);
        base_w = wr_total;
        base_e = eof_cnt;
        send_frame(20, 0, 1'b0, 1'b0, early);
        repeat (4) tick();
        chk("drop_writes", wr_total - base_w, 0);
        chk("drop_cnt_1", int'(drop_cnt), 1);
        chk("drop_pulses", eof_cnt - base_e, 0);
        chk("drop_len_kept", int'(frame_len), 64);
        release_sw();
        seed = 40;
        run_frame("after_drop", 10, 0, 1'b0, 10, 10, 0);

        // Release in the same cycle as SOF: that frame is dropped, the next accepted.
        base_w = wr_total;
        base_e = eof_cnt;
        send_frame(15, 0, 1'b0, 1'b1, early);
        repeat (3) tick();
        chk("relsof_writes", wr_total - base_w, 0);
        chk("relsof_drop_cnt", int'(drop_cnt), 2);
        chk("relsof_pulses", eof_cnt - base_e, 0);
        seed = 90;
        run_frame("after_relsof", 12, 0, 1'b0, 12, 12, 0);
        release_sw();

        // Single-byte frame: pulses two cycles after the byte.
        seed = 200;
        frame_base = wr_total;
        mac_valid = 1'b1;
        mac_data  = 8'(seed);
        mac_sof   = 1'b1;
        mac_eof   = 1'b1;
        tick();
        idle_inputs();
        chk("one_fifo_valid_n1", int'(fifo_valid), 1);
        chk("one_data_n1", int'(fifo_data), 200);
        chk("one_pulse_n1", int'(set_eof), 0);
        tick();
        chk("one_fifo_valid_n2", int'(fifo_valid), 0);
        chk("one_eof_pulse_n2", int'(set_eof), 1);
        chk("one_blk_pulse_n2", int'(set_blocked), 1);
        blocked = 1'b1;
        tick();
        chk("one_pulse_n3", int'(set_eof), 0);
        chk("one_len", int'(frame_len), 1);
        release_sw();

        // Reset at byte 20 of 50; tail bytes continue and must be ignored.
        seed = 30;
        frame_base = wr_total;
        base_w = 0;
        base_e = eof_cnt;
        for (int i = 0; i < 50; i++) begin
            mac_valid = 1'b1;
            mac_data  = 8'(seed + i);
            mac_sof   = (i == 0);
            mac_eof   = (i == 49);
            if (i == 20) rstn = 1'b0;
            if (i == 22) rstn = 1'b1;
            if (i == 21) begin
                chk("mrst_fifo_valid", int'(fifo_valid), 0);
                chk("mrst_len", int'(frame_len), 0);
                chk("mrst_status", int'(frame_status), 0);
                chk("mrst_drop", int'(drop_cnt), 0);
            end
            if (i == 23) base_w = wr_total;
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        chk("mrst_tail_writes", wr_total - base_w, 0);
        chk("mrst_tail_pulses", eof_cnt - base_e, 0);
        seed = 120;
        run_frame("post_reset", 8, 0, 1'b0, 8, 8, 0);
        chk("post_reset_drop", int'(drop_cnt), 0);
        release_sw();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
